// File: rtl/term_decoder_pkg.sv
// rtl/term_decoder_pkg.sv - shared types, defaults and level-to-code helper for term_decoder
package term_decoder_pkg;

    localparam int BIN_W_DEF   = 3;
    localparam int THERM_W_DEF = (1 << BIN_W_DEF) - 1;

    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_e;

    // Thermometer code with the low `level` bits set; callers truncate to their width.
    function automatic logic [31:0] bin2therm(input int unsigned level);
        bin2therm = (32'd1 << level) - 32'd1;
    endfunction

endpackage

// File: rtl/term_decoder_step_timer.sv
// rtl/term_decoder_step_timer.sv - dwell counter that ticks once every STEP_CYCLES enabled cycles
module term_decoder_step_timer #(
    parameter int STEP_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = $clog2(STEP_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    assign tick_o = enable_i && (count_q == CW'(STEP_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = tick_o ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/term_decoder.sv
// rtl/term_decoder.sv - binary-to-thermometer decoder that slews one segment per dwell period
module term_decoder
    import term_decoder_pkg::*;
#(
    parameter int BIN_W       = BIN_W_DEF,
    parameter int THERM_W     = 2**BIN_W - 1,
    parameter int STEP_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic [BIN_W-1:0]   binary_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [THERM_W-1:0] thermometer_o,
    output logic               busy_o,
    output logic               done_o
);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   level_q, level_d;
    logic [BIN_W-1:0]   target_q, target_d;
    logic [THERM_W-1:0] therm_q, therm_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               timer_en;
    logic               tick;

    assign accept   = valid_i && ready_o;
    assign timer_en = enable_i && (state_q == RAMP);

    term_decoder_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (accept),
        .enable_i (timer_en),
        .tick_o   (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            level_q  <= '0;
            target_q <= '0;
            therm_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            therm_q  <= therm_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // done is a pulse: it falls on every edge it is not re-asserted, including frozen ones.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        target_d = binary_i;
                        if (binary_i == level_q) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RAMP;
                            busy_d  = 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (tick) begin
                        level_d = (target_q > level_q) ? level_q + BIN_W'(1)
                                                       : level_q - BIN_W'(1);
                        if (level_d == target_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        therm_d = THERM_W'(bin2therm(32'(level_d)));
    end

    always_comb begin
        ready_o       = enable_i && (state_q == IDLE);
        thermometer_o = therm_q;
        busy_o        = busy_q;
        done_o        = done_q;
    end

endmodule

// File: tb/tb_term_decoder.sv
// tb/tb_term_decoder.sv - scoreboard bench for term_decoder with one-cycle and two-cycle dwell instances
module tb_term_decoder;
    import term_decoder_pkg::*;

    typedef struct packed {
        logic [6:0] therm;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en1, val1, ready1, busy1, done1;
    logic       en2, val2, ready2, busy2, done2;
    logic [2:0] bin1, bin2;
    logic [6:0] therm1, therm2;

    exp_t       q[$];
    exp_t       last;
    int         mdl[2];
    logic [6:0] prev[2];
    int         n_cmp;
    int         n_fail;

    term_decoder #(.BIN_W(3), .STEP_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en1), .binary_i(bin1), .valid_i(val1),
        .ready_o(ready1), .thermometer_o(therm1), .busy_o(busy1), .done_o(done1)
    );

    term_decoder #(.BIN_W(3), .STEP_CYCLES(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en2), .binary_i(bin2), .valid_i(val2),
        .ready_o(ready2), .thermometer_o(therm2), .busy_o(busy2), .done_o(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] th_of(input int l);
        th_of = 7'(bin2therm(l));
    endfunction

    task automatic push_ramp(input int from, input int to, input int sc);
        int dir;
        int d;
        if (from == to) begin
            q.push_back(exp_t'{th_of(to), 1'b0, 1'b1});
        end else begin
            dir = (to > from) ? 1 : -1;
            d   = (to > from) ? to - from : from - to;
            for (int j = 0; j < d * sc; j++) begin
                q.push_back(exp_t'{th_of(from + dir * (j / sc)), 1'b1, 1'b0});
            end
            q.push_back(exp_t'{th_of(to), 1'b0, 1'b1});
        end
    endtask

    task automatic check_cycle(input int s);
        exp_t       e;
        logic [6:0] th;
        logic       bz, dn, rd, en;
        th = (s == 0) ? therm1 : therm2;
        bz = (s == 0) ? busy1  : busy2;
        dn = (s == 0) ? done1  : done2;
        rd = (s == 0) ? ready1 : ready2;
        en = (s == 0) ? en1    : en2;
        e = q.pop_front();
        last = e;
        n_cmp += 6;
        if (th !== e.therm) begin
            n_fail++; $display("FAIL therm[%0d]: got %b expected %b", s, th, e.therm);
        end
        if (bz !== e.busy) begin
            n_fail++; $display("FAIL busy[%0d]: got %b expected %b", s, bz, e.busy);
        end
        if (dn !== e.done) begin
            n_fail++; $display("FAIL done[%0d]: got %b expected %b", s, dn, e.done);
        end
        if (rd !== (en && !e.busy)) begin
            n_fail++; $display("FAIL ready[%0d]: got %b expected %b", s, rd, en && !e.busy);
        end
        if ((th & (th + 7'd1)) !== 7'd0) begin
            n_fail++; $display("FAIL legal_code[%0d]: got %b expected a thermometer code", s, th);
        end
        if ($countones(th ^ prev[s]) > 1) begin
            n_fail++; $display("FAIL one_bit_step[%0d]: got %b after %b expected at most one bit change", s, th, prev[s]);
        end
        prev[s] = th;
    endtask

    task automatic accept(input int s, input int tgt);
        logic rd;
        if (s == 0) begin val1 = 1'b1; bin1 = 3'(tgt); end
        else        begin val2 = 1'b1; bin2 = 3'(tgt); end
        rd = (s == 0) ? ready1 : ready2;
        n_cmp++;
        if (rd !== 1'b1) begin
            n_fail++; $display("FAIL accept_ready[%0d]: got %b expected 1", s, rd);
        end
        push_ramp(mdl[s], tgt, (s == 0) ? 1 : 2);
        mdl[s] = tgt;
        @(negedge clk);
        if (s == 0) val1 = 1'b0; else val2 = 1'b0;
    endtask

    task automatic drain(input int s);
        while (q.size() > 0) begin
            check_cycle(s);
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic idle_check(input int s);
        @(negedge clk);
        q.push_back(exp_t'{th_of(mdl[s]), 1'b0, 1'b0});
        check_cycle(s);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en1 = 1'b1; en2 = 1'b0;
        val1 = 1'b0; val2 = 1'b0; bin1 = '0; bin2 = '0;
        repeat (2) @(negedge clk);
        n_cmp += 5;
        if (therm1 !== 7'b0000000) begin n_fail++; $display("FAIL reset_therm: got %b expected 0000000", therm1); end
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done1); end
        if (ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_en: got %b expected 1", ready1); end
        if (ready2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready_dis: got %b expected 0", ready2); end
        rst_n = 1'b1; en2 = 1'b1;
        idle_check(0);
        idle_check(1);
    endtask

    task automatic test_ramp_step1;
        accept(0, 5);
        drain(0);
        idle_check(0);
    endtask

    task automatic test_back_to_back_step2;
        accept(1, 6);
        drain(1);
        accept(1, 2);
        drain(1);
        idle_check(1);
    endtask

    task automatic test_zero_and_blocked;
        accept(0, 3);
        drain(0);
        accept(0, 3);
        drain(0);
        idle_check(0);
        accept(0, 6);
        val1 = 1'b1; bin1 = 3'd0;
        drain(0);
        accept(0, 0);
        drain(0);
        idle_check(0);
    endtask

    task automatic test_enable_freeze;
        accept(0, 7);
        check_cycle(0);
        @(negedge clk);
        check_cycle(0);
        @(negedge clk);
        check_cycle(0);
        en1 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            q.push_front(exp_t'{last.therm, last.busy, 1'b0});
            check_cycle(0);
        end
        en1 = 1'b1;
        @(negedge clk);
        drain(0);
    endtask

    task automatic test_reset_mid_ramp;
        accept(0, 0);
        check_cycle(0);
        @(negedge clk);
        check_cycle(0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (therm1 !== 7'b0000000) begin n_fail++; $display("FAIL async_reset_therm: got %b expected 0000000", therm1); end
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", busy1); end
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b expected 0", done1); end
        q.delete();
        mdl[0] = 0; mdl[1] = 0;
        prev[0] = '0; prev[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(0);
        idle_check(1);
        accept(0, 2);
        drain(0);
        idle_check(0);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        mdl[0] = 0; mdl[1] = 0;
        prev[0] = '0; prev[1] = '0;
        test_reset();
        test_ramp_step1();
        test_back_to_back_step2();
        test_zero_and_blocked();
        test_enable_freeze();
        test_reset_mid_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
